// File: rtl/ifetch_pkg.sv
// Shared types, constants and the PC legality check for the fetch stage.
package ifetch_pkg;

    typedef enum logic {
        RUN,
        FAULT
    } fetch_state_t;

    localparam int unsigned PC_STEP = 4;

    // Wide enough for any supported instruction width; users slice it down.
    localparam logic [63:0] BUBBLE_INSTR = '0;

    // A PC is legal when word aligned and inside the 4*2**r byte imem window.
    // Callers zero-extend their PC to 64 bits.
    function automatic logic pc_legal(input logic [63:0] pc, input int unsigned r);
        return (pc[1:0] == 2'b00) && ((pc >> (r + 2)) == 64'd0);
    endfunction

endpackage

// File: rtl/ifetch_if.sv
// Instruction-memory read port: word address out, combinational data back.
interface ifetch_if #(
    parameter int unsigned n = 32,
    parameter int unsigned r = 6
) ();

    logic [r-1:0] imem_addr;
    logic [n-1:0] imem_readdata;

    modport master (
        output imem_addr,
        input  imem_readdata
    );

    modport slave (
        input  imem_addr,
        output imem_readdata
    );

endinterface

// File: rtl/ifetch_ifid_reg.sv
// IF/ID pipeline register: clear wins over enable, otherwise hold.
module ifid_reg
    import ifetch_pkg::*;
#(
    parameter int unsigned n = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [n-1:0] instr_i,
    input  logic [n-1:0] pc_i,
    input  logic [n-1:0] pcplus4_i,
    output logic [n-1:0] instr_o,
    output logic [n-1:0] pc_o,
    output logic [n-1:0] pcplus4_o,
    output logic         valid_o
);

    logic [n-1:0] instr_q, instr_d;
    logic [n-1:0] pc_q, pc_d;
    logic [n-1:0] pcplus4_q, pcplus4_d;
    logic         valid_q, valid_d;

    // Next-state: bubble on clear, capture on enable, else hold.
    always_comb begin
        instr_d   = instr_q;
        pc_d      = pc_q;
        pcplus4_d = pcplus4_q;
        valid_d   = valid_q;
        if (clr_i) begin
            instr_d   = BUBBLE_INSTR[n-1:0];
            pc_d      = '0;
            pcplus4_d = '0;
            valid_d   = 1'b0;
        end else if (en_i) begin
            instr_d   = instr_i;
            pc_d      = pc_i;
            pcplus4_d = pcplus4_i;
            valid_d   = 1'b1;
        end
    end

    // State register with synchronous reset to an empty slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q   <= '0;
            pc_q      <= '0;
            pcplus4_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            pcplus4_q <= pcplus4_d;
            valid_q   <= valid_d;
        end
    end

    assign instr_o   = instr_q;
    assign pc_o      = pc_q;
    assign pcplus4_o = pcplus4_q;
    assign valid_o   = valid_q;

endmodule

// File: rtl/ifetch.sv
// Instruction-fetch stage: owns the PC, drives imem, fills IF/ID, traps bad PCs.
module ifetch
    import ifetch_pkg::*;
#(
    parameter int unsigned   n        = 32,
    parameter int unsigned   r        = 6,
    parameter logic [n-1:0]  RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset,
    ifetch_if.master     imem,
    input  logic         redirect,
    input  logic [n-1:0] redirect_pc,
    input  logic         stall,
    input  logic         flush,
    output logic [n-1:0] instr_d,
    output logic [n-1:0] pc_d,
    output logic [n-1:0] pcplus4_d,
    output logic         valid_d,
    output logic         fault,
    output logic [n-1:0] fault_pc
);

    fetch_state_t state_q, state_d;
    logic [n-1:0] pc_f_q, pc_f_d;
    logic [n-1:0] fault_pc_q, fault_pc_d;
    logic [n-1:0] pc_plus4;
    logic         pc_f_ok, pc_plus4_ok, redirect_ok;
    logic         ifid_en, ifid_clr;

    assign pc_plus4    = pc_f_q + n'(PC_STEP);
    assign pc_f_ok     = pc_legal(64'(pc_f_q), r);
    assign pc_plus4_ok = pc_legal(64'(pc_plus4), r);
    assign redirect_ok = pc_legal(64'(redirect_pc), r);

    assign imem.imem_addr = pc_f_q[r+1:2];

    // Next-state: PC update, IF/ID control and fault entry by priority.
    always_comb begin
        state_d    = state_q;
        pc_f_d     = pc_f_q;
        fault_pc_d = fault_pc_q;
        ifid_en    = 1'b0;
        ifid_clr   = 1'b0;
        unique case (state_q)
            RUN: begin
                if (!pc_f_ok) begin
                    // Only reachable with an illegal RESET_PC.
                    state_d    = FAULT;
                    fault_pc_d = pc_f_q;
                    ifid_clr   = 1'b1;
                end else if (redirect) begin
                    ifid_clr = 1'b1;
                    if (redirect_ok) begin
                        pc_f_d = redirect_pc;
                    end else begin
                        state_d    = FAULT;
                        fault_pc_d = redirect_pc;
                    end
                end else if (stall) begin
                    ifid_clr = flush;
                end else begin
                    ifid_en  = 1'b1;
                    ifid_clr = flush;
                    if (pc_plus4_ok) begin
                        pc_f_d = pc_plus4;
                    end else begin
                        // Deliver the last word; keep PC pointing inside imem.
                        state_d    = FAULT;
                        fault_pc_d = pc_plus4;
                    end
                end
            end
            FAULT: begin
                ifid_clr = 1'b1;
            end
            default: begin
                state_d  = FAULT;
                ifid_clr = 1'b1;
            end
        endcase
    end

    // State register; reset overrides everything, including FAULT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            pc_f_q     <= RESET_PC;
            fault_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_f_q     <= pc_f_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    ifid_reg #(
        .n (n)
    ) u_ifid_reg (
        .clk       (clk),
        .reset     (reset),
        .en_i      (ifid_en),
        .clr_i     (ifid_clr),
        .instr_i   (imem.imem_readdata),
        .pc_i      (pc_f_q),
        .pcplus4_i (pc_plus4),
        .instr_o   (instr_d),
        .pc_o      (pc_d),
        .pcplus4_o (pcplus4_d),
        .valid_o   (valid_d)
    );

    assign fault    = (state_q == FAULT);
    assign fault_pc = fault_pc_q;

    // A valid IF/ID slot always carries an in-range PC.
    assert property (@(posedge clk) disable iff (reset) valid_d |-> pc_legal(64'(pc_d), r));

    // Whatever got latched as the fault PC really was out of range.
    assert property (@(posedge clk) disable iff (reset) fault |-> !pc_legal(64'(fault_pc), r));

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: vector table plus scoreboarded free-run to imem end.
module tb_ifetch;

    localparam int unsigned N = 32;
    localparam int unsigned R = 6;

    logic         clk = 1'b0;
    logic         reset;
    logic         redirect;
    logic [N-1:0] redirect_pc;
    logic         stall;
    logic         flush;
    logic [N-1:0] instr_d;
    logic [N-1:0] pc_d;
    logic [N-1:0] pcplus4_d;
    logic         valid_d;
    logic         fault;
    logic [N-1:0] fault_pc;

    int checks   = 0;
    int failures = 0;

    ifetch_if #(.n(N), .r(R)) ifc ();

    // imem contents: word i holds A000_0000 + i.
    assign ifc.imem_readdata = 32'hA000_0000 | {26'd0, ifc.imem_addr};

    ifetch #(
        .n        (N),
        .r        (R),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem        (ifc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .flush       (flush),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .pcplus4_d   (pcplus4_d),
        .valid_d     (valid_d),
        .fault       (fault),
        .fault_pc    (fault_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        redirect;
        logic [31:0] rpc;
        logic [5:0]  exp_addr;
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc;
        logic        exp_fault;
        logic [31:0] exp_fault_pc;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } sb_t;

    vec_t vecs[20];
    sb_t  sb_q[$];

    function automatic vec_t mk(input logic s, input logic f, input logic rd,
                                input logic [31:0] rpc, input logic [5:0] a,
                                input logic v, input logic [31:0] ins,
                                input logic [31:0] pc, input logic flt,
                                input logic [31:0] fpc);
        vec_t t;
        t.stall = s;  t.flush = f;  t.redirect = rd;  t.rpc = rpc;
        t.exp_addr = a;  t.exp_valid = v;  t.exp_instr = ins;  t.exp_pc = pc;
        t.exp_fault = flt;  t.exp_fault_pc = fpc;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic f, input logic rd, input logic [31:0] rpc);
        stall = s;
        flush = f;
        redirect = rd;
        redirect_pc = rpc;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_addr"}, 64'(ifc.imem_addr), 64'd0);
        chk({tag, "_valid"}, 64'(valid_d), 64'd0);
        chk({tag, "_instr"}, 64'(instr_d), 64'd0);
        chk({tag, "_pc"}, 64'(pc_d), 64'd0);
        chk({tag, "_pcplus4"}, 64'(pcplus4_d), 64'd0);
        chk({tag, "_fault"}, 64'(fault), 64'd0);
        chk({tag, "_fault_pc"}, 64'(fault_pc), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //               st fl rd rpc       addr v  instr          pc     flt fpc
        vecs[0]  = mk(0, 0, 0, 32'd0,   6'd1,  1, 32'hA000_0000, 32'd0,  0, 32'h0);
        vecs[1]  = mk(0, 0, 0, 32'd0,   6'd2,  1, 32'hA000_0001, 32'd4,  0, 32'h0);
        vecs[2]  = mk(0, 0, 0, 32'd0,   6'd3,  1, 32'hA000_0002, 32'd8,  0, 32'h0);
        vecs[3]  = mk(0, 0, 0, 32'd0,   6'd4,  1, 32'hA000_0003, 32'd12, 0, 32'h0);
        vecs[4]  = mk(1, 0, 0, 32'd0,   6'd4,  1, 32'hA000_0003, 32'd12, 0, 32'h0);
        vecs[5]  = mk(1, 0, 0, 32'd0,   6'd4,  1, 32'hA000_0003, 32'd12, 0, 32'h0);
        vecs[6]  = mk(1, 0, 0, 32'd0,   6'd4,  1, 32'hA000_0003, 32'd12, 0, 32'h0);
        vecs[7]  = mk(0, 0, 0, 32'd0,   6'd5,  1, 32'hA000_0004, 32'd16, 0, 32'h0);
        vecs[8]  = mk(0, 1, 0, 32'd0,   6'd6,  0, 32'h0,         32'd0,  0, 32'h0);
        vecs[9]  = mk(0, 0, 0, 32'd0,   6'd7,  1, 32'hA000_0006, 32'd24, 0, 32'h0);
        vecs[10] = mk(0, 0, 0, 32'd0,   6'd8,  1, 32'hA000_0007, 32'd28, 0, 32'h0);
        vecs[11] = mk(1, 0, 1, 32'd40,  6'd10, 0, 32'h0,         32'd0,  0, 32'h0);
        vecs[12] = mk(0, 0, 0, 32'd0,   6'd11, 1, 32'hA000_000A, 32'd40, 0, 32'h0);
        vecs[13] = mk(0, 1, 1, 32'd8,   6'd2,  0, 32'h0,         32'd0,  0, 32'h0);
        vecs[14] = mk(0, 0, 0, 32'd0,   6'd3,  1, 32'hA000_0002, 32'd8,  0, 32'h0);
        vecs[15] = mk(1, 1, 0, 32'd0,   6'd3,  0, 32'h0,         32'd0,  0, 32'h0);
        vecs[16] = mk(0, 0, 0, 32'd0,   6'd4,  1, 32'hA000_0003, 32'd12, 0, 32'h0);
        vecs[17] = mk(0, 0, 1, 32'h102, 6'd4,  0, 32'h0,         32'd0,  1, 32'h102);
        vecs[18] = mk(0, 0, 1, 32'd40,  6'd4,  0, 32'h0,         32'd0,  1, 32'h102);
        vecs[19] = mk(1, 1, 0, 32'd0,   6'd4,  0, 32'h0,         32'd0,  1, 32'h102);

        reset = 1'b1;
        drive(0, 0, 0, 32'd0);
        step();
        step();
        reset = 1'b0;
        chk_reset_state("reset");

        for (int i = 0; i < 20; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(vecs[i].stall, vecs[i].flush, vecs[i].redirect, vecs[i].rpc);
            step();
            chk({tag, "_addr"}, 64'(ifc.imem_addr), 64'(vecs[i].exp_addr));
            chk({tag, "_valid"}, 64'(valid_d), 64'(vecs[i].exp_valid));
            chk({tag, "_instr"}, 64'(instr_d), 64'(vecs[i].exp_instr));
            chk({tag, "_pc"}, 64'(pc_d), 64'(vecs[i].exp_pc));
            chk({tag, "_pcplus4"}, 64'(pcplus4_d),
                vecs[i].exp_valid ? 64'(vecs[i].exp_pc + 32'd4) : 64'd0);
            chk({tag, "_fault"}, 64'(fault), 64'(vecs[i].exp_fault));
            chk({tag, "_fault_pc"}, 64'(fault_pc), 64'(vecs[i].exp_fault_pc));
        end

        // Reset taken while sitting in FAULT.
        drive(0, 0, 0, 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_reset_state("rst_in_fault");

        // Free-run to the top of imem; the last word is delivered as the fault hits.
        for (int i = 0; i < 64; i++) begin
            sb_t e;
            sb_t got;
            string tag;
            e.instr = 32'hA000_0000 + 32'(i);
            e.pc    = 32'(i) * 32'd4;
            sb_q.push_back(e);
            step();
            tag = $sformatf("run%0d", i);
            got = sb_q.pop_front();
            chk({tag, "_valid"}, 64'(valid_d), 64'd1);
            chk({tag, "_instr"}, 64'(instr_d), 64'(got.instr));
            chk({tag, "_pc"}, 64'(pc_d), 64'(got.pc));
            chk({tag, "_pcplus4"}, 64'(pcplus4_d), 64'(got.pc + 32'd4));
            chk({tag, "_fault"}, 64'(fault), (i == 63) ? 64'd1 : 64'd0);
        end
        chk("runoff_fault_pc", 64'(fault_pc), 64'h100);
        chk("runoff_sb_empty", 64'(sb_q.size()), 64'd0);

        // Once faulted, the slot drains and redirects do nothing.
        drive(0, 0, 1, 32'd16);
        step();
        chk("post_fault_valid", 64'(valid_d), 64'd0);
        chk("post_fault_instr", 64'(instr_d), 64'd0);
        chk("post_fault_fault", 64'(fault), 64'd1);
        chk("post_fault_fault_pc", 64'(fault_pc), 64'h100);
        drive(0, 0, 0, 32'd0);
        step();
        chk("post_fault2_valid", 64'(valid_d), 64'd0);
        chk("post_fault2_fault", 64'(fault), 64'd1);

        // Recovery back into RUN.
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_reset_state("final_reset");
        step();
        chk("recover_valid", 64'(valid_d), 64'd1);
        chk("recover_instr", 64'(instr_d), 64'hA000_0000);
        chk("recover_addr", 64'(ifc.imem_addr), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
